slt_compare_unit: RTL and testbench
===================================

SLT_COMPARE_UNIT -- requirements
Module: slt_compare_unit

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse, sampled only in state IDLE.
REQ-005 A  input  32  first operand (rs).
REQ-006 B  input  32  second operand (rt).
REQ-007 is_unsigned  input  1  selects sltu (1) or slt (0); present only when SLT_UNSIGNED_EN is defined.
REQ-008 LT  output  1  registered A<B result; consumed downstream by the 1-to-32 zero-extender for slt/slti write-back.
REQ-009 EQ  output  1  registered A==B result.
REQ-010 GT  output  1  registered A>B result.
REQ-011 busy  output  1  high in states CMP and DONE.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CMP and DONE.
REQ-014 IDLE->CMP: on an edge with start=1, the block SHALL latch A, B and is_unsigned into internal registers and clear the byte index to 3.
REQ-015 Signed mode SHALL compare A^32'h80000000 against B^32'h80000000 as unsigned values; unsigned mode SHALL compare the raw values.
REQ-016 CMP SHALL last exactly 4 cycles and SHALL examine one byte per cycle, from byte 3 (MSB) down to byte 0.
REQ-017 A sticky "decided" flag SHALL be set at the first differing byte, which fixes the lt/gt outcome; all later bytes SHALL be ignored.
REQ-018 Latency SHALL be fixed: for a start accepted at edge k, LT/EQ/GT SHALL update and done SHALL rise at edge k+4, regardless of data.
REQ-019 CMP->DONE SHALL occur at edge k+4; DONE->IDLE SHALL occur unconditionally at the following edge, so done is high for exactly one cycle.
REQ-020 After each completion exactly one of LT/EQ/GT SHALL be 1; EQ SHALL be 1 when no byte differed.
REQ-021 LT/EQ/GT SHALL change only at completion edges and SHALL hold their values otherwise, including across later IDLE cycles.
REQ-022 start in CMP or DONE SHALL be ignored, with no queueing; a new start SHALL be accepted in the first IDLE cycle.
REQ-023 Changes on A, B or is_unsigned after acceptance SHALL NOT affect the in-flight result.
REQ-024 Back-to-back operation SHALL be supported: one comparison every 6 cycles with start held high.

Reset
REQ-025 While reset=1 at an edge, the block SHALL enter IDLE and set LT=0, EQ=0, GT=0, busy=0, done=0, and clear the decided flag, the byte index and the operand registers.
REQ-026 Reset SHALL take priority over start.
REQ-027 Reset in CMP or DONE SHALL abort the operation, and no done pulse SHALL follow.

Configuration
REQ-028 Macro SLT_UNSIGNED_EN defined: the is_unsigned port SHALL exist, and is_unsigned=1 SHALL select the raw unsigned compare.
REQ-029 Macro SLT_UNSIGNED_EN undefined: the is_unsigned port SHALL be absent, and every compare SHALL be signed.

Verification
REQ-030 Reset, then start with A=32'h00000005, B=32'h00000007 -> done exactly 4 cycles after acceptance, LT=1, EQ=0, GT=0.
REQ-031 Signed mode, A=32'hFFFFFFFF (-1), B=32'h00000001 -> LT=1; with SLT_UNSIGNED_EN and is_unsigned=1, same operands -> GT=1.
REQ-032 A=B=32'h12345678 -> EQ=1; then A=32'h12345679, B=32'h12345678 (difference only in byte 0) -> GT=1; A=32'h80000000, B=32'h7FFFFFFF, signed -> LT=1.
REQ-033 Start re-pulsed during CMP, with A/B changed mid-operation -> first result is unaffected, the second pulse is ignored, and done pulses once.
REQ-034 Reset asserted at CMP cycle 2 -> outputs become 0 at the next edge, no done pulse follows, and the next start completes normally.
REQ-035 Start held high for 18 cycles -> exactly 3 done pulses spaced 6 cycles apart, with LT/EQ/GT stable between completions.

Source files
------------

// File: rtl/slt_compare_unit.sv
// Byte-serial set-less-than comparator: 4-cycle compare, registered LT/EQ/GT.
// Optional SLT_UNSIGNED_EN adds the is_unsigned port (sltu); default is signed-only.
module slt_compare_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef SLT_UNSIGNED_EN
  input  logic        is_unsigned,
`endif
  output logic        LT,
  output logic        EQ,
  output logic        GT,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // CMP   | one byte per cycle, byte 3 down to byte 0
  // DONE  | one-cycle completion, done high
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  idx_q, idx_d;
  logic        decided_q, decided_d;
  logic        dlt_q, dlt_d;
  logic        lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic        signed_cmp;
  logic [7:0]  a_byte, b_byte;

`ifdef SLT_UNSIGNED_EN
  logic        uns_q, uns_d;
  assign signed_cmp = ~uns_q;
`else
  assign signed_cmp = 1'b1;
`endif

  // Signed compare is an unsigned compare with both sign bits inverted.
  always_comb begin
    case (idx_q)
      2'd3:    begin a_byte = a_q[31:24]; b_byte = b_q[31:24]; end
      2'd2:    begin a_byte = a_q[23:16]; b_byte = b_q[23:16]; end
      2'd1:    begin a_byte = a_q[15:8];  b_byte = b_q[15:8];  end
      default: begin a_byte = a_q[7:0];   b_byte = b_q[7:0];   end
    endcase
    if (signed_cmp && (idx_q == 2'd3)) begin
      a_byte[7] = ~a_byte[7];
      b_byte[7] = ~b_byte[7];
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    dlt_d     = dlt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
`ifdef SLT_UNSIGNED_EN
    uns_d     = uns_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = A;
          b_d       = B;
          idx_d     = 2'd3;
          decided_d = 1'b0;
          dlt_d     = 1'b0;
`ifdef SLT_UNSIGNED_EN
          uns_d     = is_unsigned;
`endif
          state_d   = CMP;
        end
      end
      CMP: begin
        if (!decided_q && (a_byte != b_byte)) begin
          decided_d = 1'b1;
          dlt_d     = (a_byte < b_byte);
        end
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          lt_d    = decided_d & dlt_d;
          gt_d    = decided_d & ~dlt_d;
          eq_d    = ~decided_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      dlt_q     <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
`ifdef SLT_UNSIGNED_EN
      uns_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      dlt_q     <= dlt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
`ifdef SLT_UNSIGNED_EN
      uns_q     <= uns_d;
`endif
    end
  end

  assign LT   = lt_q;
  assign EQ   = eq_q;
  assign GT   = gt_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_slt_compare_unit.sv
// Directed bench for slt_compare_unit: vector table plus multi-cycle corner sequences.
module tb_slt_compare_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        is_unsigned = 1'b0;
  logic        LT, EQ, GT, busy, done;

  int tests = 0;
  int fails = 0;

  slt_compare_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .A(A),
    .B(B),
`ifdef SLT_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .LT(LT),
    .EQ(EQ),
    .GT(GT),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        lt;
    logic        eq;
    logic        gt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op from IDLE; checks fixed 4-cycle latency and the result flags.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input logic elt, input logic eeq, input logic egt);
    int n;
    A = a; B = b; is_unsigned = uns; start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, " busy_after_accept"}, {31'b0, busy}, 32'd1);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done) begin n = i; break; end
    end
    chk({name, " latency"}, n, 32'd4);
    chk({name, " LT"}, {31'b0, LT}, {31'b0, elt});
    chk({name, " EQ"}, {31'b0, EQ}, {31'b0, eeq});
    chk({name, " GT"}, {31'b0, GT}, {31'b0, egt});
    tick();
    chk({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
    chk({name, " idle_not_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int dcount;
    int dcyc[$];
    logic plt, peq, pgt;

    vecs[0] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h12345679, 32'h12345678, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h01000000, 32'h00FFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{32'h12FF0000, 32'h13000000, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    tick(); tick();
    chk("reset LT", {31'b0, LT}, 32'd0);
    chk("reset EQ", {31'b0, EQ}, 32'd0);
    chk("reset GT", {31'b0, GT}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    // reset wins over start
    start = 1'b1;
    tick();
    chk("reset_over_start busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, vecs[i].lt, vecs[i].eq, vecs[i].gt);

`ifdef SLT_UNSIGNED_EN
    run_op("sltu_ffff_vs_1", 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sltu_0_vs_ffff", 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Restart during CMP with operands changed: ignored, single done.
    A = 32'h00000001; B = 32'h00000002; start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 1) begin A = 32'h00000009; B = 32'h00000002; start = 1'b1; end
      if (i == 3) start = 1'b0;
      tick();
      if (done) dcount++;
    end
    chk("restart done_count", dcount, 32'd1);
    chk("restart LT", {31'b0, LT}, 32'd1);
    chk("restart GT", {31'b0, GT}, 32'd0);

    // Reset in CMP cycle 2 aborts the op.
    A = 32'h00000009; B = 32'h00000003; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("abort LT", {31'b0, LT}, 32'd0);
    chk("abort EQ", {31'b0, EQ}, 32'd0);
    chk("abort GT", {31'b0, GT}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dcount++;
    end
    chk("abort no_done", dcount, 32'd0);
    run_op("after_abort", 32'h00000009, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b1);

    // start held 18 cycles: three ops (LT, EQ, GT) every 6 cycles.
    A = 32'h00000001; B = 32'h00000002; start = 1'b1;
    plt = LT; peq = EQ; pgt = GT;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i == 1) begin A = 32'h00000005; B = 32'h00000005; end
      if (i == 7) begin A = 32'h00000009; B = 32'h00000001; end
      if (i == 18) start = 1'b0;
      if (done) begin
        dcyc.push_back(i);
        case (dcyc.size())
          1: chk("held op1 LT", {29'b0, LT, EQ, GT}, 32'b100);
          2: chk("held op2 EQ", {29'b0, LT, EQ, GT}, 32'b010);
          3: chk("held op3 GT", {29'b0, LT, EQ, GT}, 32'b001);
          default: chk("held extra_done", dcyc.size(), 32'd3);
        endcase
      end else begin
        chk($sformatf("held stable c%0d", i), {29'b0, LT, EQ, GT}, {29'b0, plt, peq, pgt});
      end
      plt = LT; peq = EQ; pgt = GT;
    end
    chk("held done_count", dcyc.size(), 32'd3);
    if (dcyc.size() == 3) begin
      chk("held first_done", dcyc[0], 32'd5);
      chk("held spacing1", dcyc[1] - dcyc[0], 32'd6);
      chk("held spacing2", dcyc[2] - dcyc[1], 32'd6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
